// File: rtl/frequency_generator_pkg.sv
// Shared definitions for the frequency generator: data width, divider
// iteration count and the control FSM state encoding.
package frequency_generator_pkg;

    localparam int DATA_W    = 32;
    localparam int REM_W     = DATA_W + 1;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } state_t;

endpackage

// File: rtl/frequency_generator_serial_divider.sv
// Unsigned 32/32 restoring divider producing one quotient bit per clock.
// Start loads the operands; the iterations then run on the following
// DIV_ITERS edges. Done is asserted during the cycle of the final
// iteration, and Quotient carries the value that iteration completes.
// A consumer sampling Quotient on the edge where Done is high therefore
// sees the finished result on the same edge the divider goes idle.
module serial_divider
    import frequency_generator_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [DATA_W-1:0] Dividend,
    input  logic [DATA_W-1:0] Divisor,
    output logic              Done,
    output logic [DATA_W-1:0] Quotient
);

    logic [REM_W-1:0]  rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic [CNT_W-1:0]  count;
    logic              busy;

    logic [REM_W:0]    trial;
    logic              fits;
    logic [REM_W-1:0]  rem_next;
    logic [DATA_W-1:0] quo_next;

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits
    always_comb begin
        trial    = {rem, quo[DATA_W-1]};
        fits     = (trial >= {2'b00, dvs});
        rem_next = fits ? REM_W'(trial - {2'b00, dvs}) : REM_W'(trial);
        quo_next = {quo[DATA_W-2:0], fits};
        Done     = busy && (count == CNT_W'(DIV_ITERS - 1));
        Quotient = quo_next;
    end

    // Operand capture on Start, then one iteration per clock until the count runs out
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (Start && !busy) begin
            rem   <= '0;
            quo   <= Dividend;
            dvs   <= Divisor;
            count <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (Done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frequency_generator.sv
// Square-wave source: turns a requested frequency in Hz into a half-period
// in clock cycles with a serial divider and drives a 50 % duty signal.
// A new half-period is only adopted while the output is stopped or at the
// instant the output is about to rise, so no partial period is produced.
module frequency_generator
    import frequency_generator_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] Freq,
    input  logic              Load,
    input  logic              Enable,
    output logic              Sig,
    output logic              Tick,
    output logic              Ready,
    output logic              Err
);

    localparam logic [DATA_W-1:0] CLK_WORD = DATA_W'(CLK_HZ);
    localparam logic [DATA_W-1:0] MAX_FREQ = DATA_W'(CLK_HZ / 2);

    state_t            state;
    state_t            state_next;

    logic              freq_valid;
    logic              load_seen;
    logic              load_ok;
    logic [DATA_W-1:0] divisor;

    logic              div_done;
    logic [DATA_W-1:0] div_quotient;

    logic [DATA_W-1:0] pending;
    logic              pending_flag;
    logic [DATA_W-1:0] half_period;
    logic [DATA_W-1:0] half_count;
    logic              running;

    logic              run_cond;
    logic              at_limit;
    logic              rise;
    logic              transfer;

    // Request decode: a load is only looked at while idle; zero and anything above Nyquist are rejected
    always_comb begin
        freq_valid = (Freq != '0) && (Freq <= MAX_FREQ);
        load_seen  = Load && (state == IDLE);
        load_ok    = load_seen && freq_valid;
        divisor    = {Freq[DATA_W-2:0], 1'b0};
    end

    serial_divider u_divider (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (load_ok),
        .Dividend (CLK_WORD),
        .Divisor  (divisor),
        .Done     (div_done),
        .Quotient (div_quotient)
    );

    // Control state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on an accepted load, return when the divider finishes
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_ok)  state_next = DIVIDE;
            DIVIDE:  if (div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: loads are accepted only while idle
    always_comb begin
        Ready = (state == IDLE);
    end

    // Error flag follows the verdict of the most recent load seen while idle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Err <= 1'b0;
        end else if (load_seen) begin
            Err <= !freq_valid;
        end
    end

    // Period boundary detection: the output rises either on a fresh start or at the end of a low phase
    always_comb begin
        run_cond = Enable && (half_period != '0);
        at_limit = (half_count == half_period - 1'b1);
        rise     = run_cond && (!running || (at_limit && !Sig));
        transfer = pending_flag && (!run_cond || rise);
    end

    // Pending result from the divider, held until the output is stopped or about to rise
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending      <= '0;
            pending_flag <= 1'b0;
        end else if (div_done) begin
            pending      <= div_quotient;
            pending_flag <= 1'b1;
        end else if (transfer) begin
            pending_flag <= 1'b0;
        end
    end

    // Active half-period; zero means nothing has been configured yet
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            half_period <= '0;
        end else if (transfer) begin
            half_period <= pending;
        end
    end

    // Half-period counter and registered output: start high on enable, toggle every half-period
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            half_count <= '0;
            running    <= 1'b0;
            Sig        <= 1'b0;
            Tick       <= 1'b0;
        end else if (!run_cond) begin
            half_count <= '0;
            running    <= 1'b0;
            Sig        <= 1'b0;
            Tick       <= 1'b0;
        end else if (!running) begin
            half_count <= '0;
            running    <= 1'b1;
            Sig        <= 1'b1;
            Tick       <= 1'b1;
        end else if (at_limit) begin
            half_count <= '0;
            Sig        <= !Sig;
            Tick       <= !Sig;
        end else begin
            half_count <= half_count + 1'b1;
            Tick       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench for frequency_generator at CLK_HZ = 1000. A period-level
// reference model (period start time plus half-period) is compared against the
// DUT on every falling edge; directed scenarios add hand-computed period,
// duty and latency expectations.
module tb_frequency_generator;

    localparam int CLK_HZ = 1000;

    logic        Clk    = 1'b0;
    logic        Rst_n  = 1'b0;
    logic [31:0] Freq   = '0;
    logic        Load   = 1'b0;
    logic        Enable = 1'b0;
    logic        Sig;
    logic        Tick;
    logic        Ready;
    logic        Err;

    int tests_run    = 0;
    int tests_failed = 0;
    bit checking     = 1'b0;

    // Reference model state
    int m_busy;
    int m_q;
    int m_pend_val;
    bit m_pend;
    int m_h;
    bit m_sig;
    bit m_tick;
    bit m_running;
    int m_pos;
    bit m_ready;
    bit m_err;

    frequency_generator #(.CLK_HZ(CLK_HZ)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Freq   (Freq),
        .Load   (Load),
        .Enable (Enable),
        .Sig    (Sig),
        .Tick   (Tick),
        .Ready  (Ready),
        .Err    (Err)
    );

    // Free-running system clock
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_busy     = 0;
        m_q        = 0;
        m_pend_val = 0;
        m_pend     = 1'b0;
        m_h        = 0;
        m_sig      = 1'b0;
        m_tick     = 1'b0;
        m_running  = 1'b0;
        m_pos      = 0;
        m_ready    = 1'b1;
        m_err      = 1'b0;
    endtask

    task automatic modelAdopt();
        if (m_pend) begin
            m_h    = m_pend_val;
            m_pend = 1'b0;
        end
    endtask

    // Period view: high while the position in the period is below H, new period after 2H cycles
    task automatic modelStep();
        bit run_now;
        run_now = Enable && (m_h != 0);
        if (!run_now) begin
            modelAdopt();
            m_sig     = 1'b0;
            m_tick    = 1'b0;
            m_running = 1'b0;
        end else if (!m_running) begin
            modelAdopt();
            m_running = 1'b1;
            m_pos     = 0;
            m_sig     = 1'b1;
            m_tick    = 1'b1;
        end else begin
            m_pos++;
            if (m_pos == 2 * m_h) begin
                modelAdopt();
                m_pos = 0;
            end
            m_sig  = (m_pos < m_h);
            m_tick = (m_pos == 0);
        end

        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_pend_val = m_q;
                m_pend     = 1'b1;
                m_ready    = 1'b1;
            end
        end else if (Load) begin
            if (Freq == 0 || int'(Freq) > CLK_HZ / 2) begin
                m_err = 1'b1;
            end else begin
                m_err   = 1'b0;
                m_q     = CLK_HZ / (2 * int'(Freq));
                m_busy  = 32;
                m_ready = 1'b0;
            end
        end
    endtask

    // Model advances on every rising edge and follows the asynchronous reset
    initial begin
        modelReset();
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) modelReset();
            else        modelStep();
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge Clk);
            if (checking) begin
                checkOutput("cyc_sig",   int'(Sig),   int'(m_sig));
                checkOutput("cyc_tick",  int'(Tick),  int'(m_tick));
                checkOutput("cyc_ready", int'(Ready), int'(m_ready));
                checkOutput("cyc_err",   int'(Err),   int'(m_err));
            end
        end
    end

    task automatic applyStimulus(input logic ld, input logic [31:0] f, input logic en);
        Load   = ld;
        Freq   = f;
        Enable = en;
        @(negedge Clk);
        Load   = 1'b0;
    endtask

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (!Ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        checkOutput({name, "_ready_wait"}, int'(Ready), 1);
        @(negedge Clk);
    endtask

    task automatic measurePeriod(input string name, input int exp_per, input int exp_high);
        int n;
        int per;
        int high;
        bit waited_out;
        n = 0;
        while (!Tick && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        waited_out = !Tick;
        checkOutput({name, "_tick_wait"}, int'(waited_out), 0);
        per  = 0;
        high = 0;
        do begin
            if (Sig) high++;
            per++;
            @(negedge Clk);
        end while (!Tick && per < 3000);
        checkOutput({name, "_period"}, per, exp_per);
        checkOutput({name, "_high"}, high, exp_high);
    endtask

    initial begin
        int n;
        int cnt;

        // Reset state
        repeat (3) @(negedge Clk);
        checking = 1'b1;
        checkOutput("reset_sig",   int'(Sig),   0);
        checkOutput("reset_tick",  int'(Tick),  0);
        checkOutput("reset_ready", int'(Ready), 1);
        checkOutput("reset_err",   int'(Err),   0);
        checkOutput("model_h_reset", m_h, 0);
        Rst_n  = 1'b1;
        Enable = 1'b1;
        repeat (2) @(negedge Clk);

        // Basic setting: 100 Hz -> H=5, period 10
        applyStimulus(1'b1, 32'd100, 1'b1);
        cnt = 0;
        while (!Ready && cnt < 40) begin
            cnt++;
            @(negedge Clk);
        end
        checkOutput("basic_ready_low_cycles", cnt, 32);
        measurePeriod("basic", 10, 5);
        measurePeriod("basic_again", 10, 5);
        checkOutput("model_h_100", m_h, 5);

        // Range errors keep the running setting
        applyStimulus(1'b1, 32'd0, 1'b1);
        checkOutput("err_zero", int'(Err), 1);
        checkOutput("err_zero_ready", int'(Ready), 1);
        applyStimulus(1'b1, 32'd501, 1'b1);
        checkOutput("err_501", int'(Err), 1);
        checkOutput("err_501_ready", int'(Ready), 1);
        measurePeriod("err_hold", 10, 5);
        applyStimulus(1'b1, 32'd200, 1'b1);
        checkOutput("err_cleared", int'(Err), 0);
        waitReady("f200");
        measurePeriod("f200", 4, 2);

        // Edge-of-range values
        applyStimulus(1'b1, 32'd500, 1'b1);
        waitReady("f500");
        measurePeriod("f500", 2, 1);
        applyStimulus(1'b1, 32'd300, 1'b1);
        waitReady("f300");
        measurePeriod("f300", 2, 1);
        applyStimulus(1'b1, 32'd1, 1'b1);
        waitReady("f1");
        measurePeriod("f1", 1000, 500);
        checkOutput("model_h_1", m_h, 500);

        // Glitch-free retune from 100 Hz to 50 Hz in the middle of a high phase
        applyStimulus(1'b1, 32'd100, 1'b1);
        waitReady("retune_base");
        measurePeriod("retune_base", 10, 5);
        applyStimulus(1'b1, 32'd50, 1'b1);
        n = 0;
        while (!Tick && n < 100) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("retune_old_period_rest", n, 9);
        waitReady("retune");
        measurePeriod("retune_new", 20, 10);

        // Enable gating for 7 cycles
        Enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            if (Sig || Tick) cnt++;
        end
        checkOutput("gate_quiet_cycles", cnt, 0);
        Enable = 1'b1;
        @(negedge Clk);
        checkOutput("gate_restart_sig",  int'(Sig),  1);
        checkOutput("gate_restart_tick", int'(Tick), 1);
        measurePeriod("gate_after", 20, 10);

        // Reset in the middle of a division
        applyStimulus(1'b1, 32'd0, 1'b1);
        checkOutput("pre_reset_err", int'(Err), 1);
        applyStimulus(1'b1, 32'd100, 1'b1);
        repeat (14) @(negedge Clk);
        checkOutput("pre_reset_busy", int'(Ready), 0);
        #2 Rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_sig",   int'(Sig),   0);
        checkOutput("mid_reset_tick",  int'(Tick),  0);
        checkOutput("mid_reset_ready", int'(Ready), 1);
        checkOutput("mid_reset_err",   int'(Err),   0);
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Sig) cnt++;
        end
        checkOutput("post_reset_sig_high", cnt, 0);
        applyStimulus(1'b1, 32'd250, 1'b1);
        waitReady("recover");
        measurePeriod("recover", 4, 2);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frequency_generator.md
# frequency_generator

Square-wave source that is the transmit counterpart of the on-chip frequency counter. It accepts a requested output frequency in Hz, converts it to a half-period in system-clock cycles with a serial divider, and drives a 50 % duty-cycle signal on `Sig`. New settings are applied glitch-free at a period boundary. A frequency counter wired to `Sig` closes a self-test loop.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz; must be < 2^32.
- `Clk`  in  1: system clock; all logic on the rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `Freq`  in  32: requested frequency in Hz; sampled only when `Load` is accepted.
- `Load`  in  1: single-cycle request strobe; accepted only while `Ready`=1.
- `Enable`  in  1: output enable; low forces `Sig` low.
- `Sig`  out  1: generated square wave; reset 0.
- `Tick`  out  1: one-cycle pulse on the cycle `Sig` goes 0→1; reset 0.
- `Ready`  out  1: able to accept `Load`; reset 1.
- `Err`  out  1: last `Load` rejected; sticky until the next accepted `Load`; reset 0.

## Operation
- FSM states:
  - IDLE: `Ready`=1.
  - DIVIDE: `Ready`=0.
- IDLE + `Load`:
  - `Freq`==0 or `Freq` > CLK_HZ/2: set `Err`=1, stay in IDLE, leave the active setting unchanged.
  - Otherwise: clear `Err`, latch divisor = 2·`Freq` (32 bits; no overflow in range), go to DIVIDE.
- DIVIDE: restoring divider, one quotient bit per cycle, 32 cycles.
  - Dividend: CLK_HZ.
  - Remainder register: 33 bits.
  - Quotient Q = floor(CLK_HZ / (2·`Freq`)); Q ≥ 1 is guaranteed by the range check.
  - After the last iteration: Pending = Q, set the pending flag, return to IDLE.
- `Load` while `Ready`=0 is ignored; no error is flagged.
- Active half-period H:
  - Reset value 0, meaning unconfigured; `Sig` is held low while H=0.
  - H is replaced by Pending (and the pending flag cleared) in either case:
    - the counter is idle: H=0 or `Enable`=0, giving immediate transfer;
    - a falling→rising boundary, i.e. the cycle `Sig` is about to go 0→1.
  - So no partial period is ever produced.
- Half-period counter HC, 32 bits:
  - Runs while `Enable`=1 and H≠0.
  - At HC = H−1: toggle `Sig` and clear HC; otherwise increment.
  - Output frequency = CLK_HZ / (2·H); truncation error is inherent and accepted.
- `Enable` low:
  - HC=0, `Sig`=0, `Tick`=0.
  - The pending flag still transfers to H.
- `Enable` rising with H≠0: `Sig` goes high on the first edge where `Enable` is sampled high; `Tick` pulses on that same cycle.
- Simultaneous pending transfer and boundary: the new H governs the upcoming high phase.
- Reset mid-DIVIDE: the division is aborted and all state returns to reset values, including H=0.

## Timing
- `Load` sampled at edge k (valid): `Ready`=0 after k; DIVIDE iterations run on edges k+1..k+32; `Ready`=1 and Pending valid after edge k+32.
- Invalid `Load` at edge k: `Err`=1 after edge k; `Ready` never drops.
- New H takes effect at most one full old period after Pending becomes valid.
- `Sig` and `Tick` are registered outputs with no combinational path from inputs.
- Maximum output frequency is CLK_HZ/2 (H=1, `Sig` toggles every cycle).

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, DIVIDE);
  - the 32-bit data width constant;
  - the divider iteration count of 32.
- One sub-module, `serial_divider`:
  - unsigned 32/32 restoring divider;
  - `Start`/`Done` handshake with `Clk` and `Rst_n`;
  - instantiated once for the half-period computation.
- Period counter, output register and transfer logic stay in the top module.

## Test plan
- Basic setting: CLK_HZ=1000, `Enable`=1, `Load` `Freq`=100 → `Ready` low for exactly 32 cycles; then `Sig` has period 10 clk, 5 high / 5 low, and `Tick` fires every 10 cycles.
- Range errors: `Load` `Freq`=0, then `Freq`=501 → `Err`=1 each time; `Ready` stays 1; `Sig` keeps its previous period. A following valid `Load` clears `Err`.
- Edge-of-range values (CLK_HZ=1000): `Freq`=500 → `Sig` toggles every cycle; `Freq`=300 → H=1, also period 2; `Freq`=1 → period 1000.
- Glitch-free retune: running at `Freq`=100, `Load` `Freq`=50 mid-high-phase → the current period completes at 10 clk, and the next rising edge starts 20-clk periods; no high or low phase differs from 5 or 10.
- Enable gating: drop `Enable` for 7 cycles → `Sig`=0 and no `Tick`; re-raise → `Sig`=1 and `Tick` on the first enabled edge.
- Reset: assert `Rst_n` low at DIVIDE cycle 15 → immediately `Sig`=0, `Ready`=1, `Err`=0, H=0. After release, `Sig` stays low until a new `Load` completes.
